// File: rtl/irq_ctrl.sv
// irq_ctrl -- edge-triggered, maskable, fixed-priority interrupt controller.
//
// Collects rising edges from N_SRC request lines into pending bits, picks the
// lowest-index unmasked pending source, and raises a registered `interrupt`
// that is held until the core can redirect its PC (pc_write high). The
// selected source is then in service until the handler pulses `eoi`; no other
// interrupt is presented meanwhile (no nesting).
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-low reset
//   irq_src     raw request lines, synchronous to clk
//   cfg_we      mask write strobe
//   cfg_mask    new mask value, bit=1 enables that source
//   pc_write    core PC-update enable (low = core stalled)
//   eoi         end-of-interrupt pulse from the handler
//   interrupt   registered request to the core
//   irq_id      index of the source being fired or serviced
//   in_service  high from acceptance until eoi
//   pending     current pending bits
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [N_SRC-1:0] cfg_mask,
  input  logic             pc_write,
  input  logic             eoi,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q;
  logic [ID_W-1:0]  id_q, id_d;
  logic             int_q, int_d;
  logic             svc_q, svc_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  win_id;

  // src_q resets to 0, so a line already high when reset lifts is an edge.
  assign rise = irq_src & ~src_q;
  assign req  = pending_q & mask_q;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    int_d   = int_q;
    svc_d   = svc_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = FIRE;
          id_d    = win_id;
          int_d   = 1'b1;
        end
      end
      FIRE: begin
        // Acceptance cycle: the core takes the redirect now.
        if (pc_write) begin
          state_d = SERVICE;
          clr     = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;
          int_d   = 1'b0;
          svc_d   = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
          svc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
        svc_d   = 1'b0;
      end
    endcase
    // OR-ing the new edges last makes a same-cycle set beat the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      int_q     <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      if (cfg_we) mask_q <= cfg_mask;
      id_q      <= id_d;
      int_q     <= int_d;
      svc_q     <= svc_d;
    end
  end

  assign interrupt  = int_q;
  assign irq_id     = id_q;
  assign in_service = svc_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed stimulus; each expected interrupt pulse
// (source id, pending bits while firing, pulse length) is queued by the
// stimulus and checked by an independent monitor watching `interrupt`.
module tb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] irq_src;
  logic             cfg_we;
  logic [N_SRC-1:0] cfg_mask;
  logic             pc_write;
  logic             eoi;
  logic             interrupt;
  logic [ID_W-1:0]  irq_id;
  logic             in_service;
  logic [N_SRC-1:0] pending;

  irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we),
    .cfg_mask(cfg_mask), .pc_write(pc_write), .eoi(eoi),
    .interrupt(interrupt), .irq_id(irq_id), .in_service(in_service),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned pend;
    int unsigned len;
  } fire_t;

  fire_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_fire(int unsigned id, int unsigned pend, int unsigned len);
    fire_t f;
    f.id = id; f.pend = pend; f.len = len;
    exp_q.push_back(f);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  logic  mon_hi = 1'b0;
  logic  mon_cur_ok = 1'b0;
  int    mon_cnt = 0;
  fire_t mon_cur;

  always @(negedge clk) begin
    if (!rst) begin
      mon_hi  = 1'b0;
      mon_cnt = 0;
    end else if (interrupt && !mon_hi) begin
      mon_hi  = 1'b1;
      mon_cnt = 1;
      if (exp_q.size() == 0) begin
        mon_cur_ok = 1'b0;
        check("unexpected_interrupt_id", irq_id, 32'hffff_ffff);
      end else begin
        mon_cur    = exp_q.pop_front();
        mon_cur_ok = 1'b1;
        check("fire_irq_id", irq_id, mon_cur.id);
        check("fire_pending", pending, mon_cur.pend);
      end
    end else if (interrupt && mon_hi) begin
      mon_cnt++;
      if (mon_cur_ok) check("fire_id_stable", irq_id, mon_cur.id);
    end else if (!interrupt && mon_hi) begin
      mon_hi = 1'b0;
      if (mon_cur_ok) begin
        check("pulse_len", mon_cnt, mon_cur.len);
        check("in_service_after_accept", in_service, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [N_SRC-1:0] m);
    cfg_we = 1'b1; cfg_mask = m;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_mask = '0;
    pc_write = 1'b1; eoi = 1'b0;
    #3;
    check("rst_interrupt", interrupt, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_in_service", in_service, 0);
    check("rst_pending", pending, 0);
    #9 rst = 1'b1;
    step();

    // 1: single source
    write_mask(8'hFF);
    irq_src = 8'h20; step(); irq_src = '0;
    expect_fire(5, 8'h20, 1);
    check("t1_pending_set", pending, 8'h20);
    check("t1_int_not_yet", interrupt, 0);
    step();
    check("t1_int", interrupt, 1);
    check("t1_id", irq_id, 5);
    check("t1_in_service_fire", in_service, 0);
    step();
    check("t1_int_drop", interrupt, 0);
    check("t1_in_service", in_service, 1);
    check("t1_pending_clr", pending, 0);
    do_eoi();
    check("t1_eoi", in_service, 0);
    step();

    // 2: priority and back-to-back spacing
    irq_src = 8'h44; step(); irq_src = '0;
    expect_fire(2, 8'h44, 1);
    expect_fire(6, 8'h40, 1);
    step();
    check("t2_first_id", irq_id, 2);
    step();
    check("t2_left_pending", pending, 8'h40);
    check("t2_svc", in_service, 1);
    do_eoi();
    check("t2_idle_gap", interrupt, 0);
    step();
    check("t2_second_int", interrupt, 1);
    check("t2_second_id", irq_id, 6);
    step();
    check("t2_second_clr", pending, 0);
    do_eoi();
    step();

    // 3: stall
    pc_write = 1'b0;
    irq_src = 8'h01; step(); irq_src = '0;
    expect_fire(0, 8'h01, 4);
    step();
    check("t3_int", interrupt, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_int_held", interrupt, 1);
      check("t3_id_held", irq_id, 0);
      check("t3_pend_held", pending, 8'h01);
      check("t3_svc_low", in_service, 0);
    end
    pc_write = 1'b1;
    step();
    check("t3_accept_int", interrupt, 0);
    check("t3_accept_pend", pending, 0);
    check("t3_accept_svc", in_service, 1);
    do_eoi();
    step();

    // 4: masking
    write_mask(8'h00);
    irq_src = 8'h08; step(); irq_src = '0;
    check("t4_pend_masked", pending, 8'h08);
    step(); step();
    check("t4_no_int", interrupt, 0);
    write_mask(8'h08);
    expect_fire(3, 8'h08, 1);
    check("t4_not_yet", interrupt, 0);
    step();
    check("t4_int", interrupt, 1);
    check("t4_id", irq_id, 3);
    step();
    do_eoi();
    write_mask(8'hFF);

    // 5a: service blocking
    irq_src = 8'h02; step(); irq_src = '0;
    expect_fire(1, 8'h02, 1);
    step(); step();
    check("t5_svc", in_service, 1);
    irq_src = 8'h03; step(); irq_src = '0;
    step(); step();
    check("t5_blocked", interrupt, 0);
    check("t5_pend", pending, 8'h03);
    check("t5_id_kept", irq_id, 1);
    expect_fire(0, 8'h03, 1);
    expect_fire(1, 8'h02, 1);
    do_eoi();
    step(); step();
    do_eoi();
    step(); step();
    do_eoi();
    step();

    // 5b: set wins over clear in the acceptance cycle
    irq_src = 8'h10; step(); irq_src = '0;
    expect_fire(4, 8'h10, 1);
    step();
    irq_src = 8'h10;
    step();
    irq_src = '0;
    check("t5_set_wins", pending, 8'h10);
    expect_fire(4, 8'h10, 1);
    do_eoi();
    step(); step();
    check("t5_refire_clr", pending, 0);
    do_eoi();
    step();

    // 6: reset in FIRE
    irq_src = 8'h04; step(); irq_src = '0;
    step();
    check("t6_fire_before_rst", interrupt, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_fire_rst_int", interrupt, 0);
    check("t6_fire_rst_id", irq_id, 0);
    check("t6_fire_rst_pend", pending, 0);
    step();
    rst = 1'b1;
    write_mask(8'hFF);

    // 6: reset in SERVICE
    irq_src = 8'h04; step(); irq_src = '0;
    expect_fire(2, 8'h04, 1);
    step(); step();
    check("t6_svc_before_rst", in_service, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_svc_rst_svc", in_service, 0);
    check("t6_svc_rst_id", irq_id, 0);
    check("t6_svc_rst_int", interrupt, 0);
    irq_src = 8'h01; cfg_we = 1'b1; cfg_mask = 8'h01;
    step();
    rst = 1'b1;
    step();
    cfg_we = 1'b0;
    check("t6_held_edge", pending, 8'h01);
    expect_fire(0, 8'h01, 1);
    step();
    check("t6_int", interrupt, 1);
    check("t6_id", irq_id, 0);
    step();
    do_eoi();
    for (int i = 0; i < 8; i++) step();
    check("t6_no_repeat_int", interrupt, 0);
    check("t6_no_repeat_pend", pending, 0);
    irq_src = '0;
    step();
    check("all_fires_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Edge-triggered, maskable, fixed-priority interrupt controller that drives the core's single `interrupt` input. It collects rising edges from up to `N_SRC` sources into pending bits and selects the highest-priority unmasked request. It presents the request to the core as a pulse that is held until the core can redirect its PC. It then blocks further requests until the handler signals end-of-interrupt. The core redirects to the fixed handler address 0x80000180 and latches EPC when `interrupt` is high.

## Interface
- `N_SRC`, default 8: number of interrupt sources, 2..32.
- `ID_W`, default 3: width of `irq_id`; must satisfy 2^ID_W >= N_SRC.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `irq_src`  in  N_SRC  raw request lines, already synchronous to `clk`.
- `cfg_we`  in  1  mask write strobe.
- `cfg_mask`  in  N_SRC  new mask value; bit=1 enables that source.
- `pc_write`  in  1  core PC-update enable; low means the core is stalled.
- `eoi`  in  1  end-of-interrupt pulse from the handler.
- `interrupt`  out  1  request to the core (registered).
- `irq_id`  out  ID_W  index of the source being fired or serviced.
- `in_service`  out  1  high from acceptance until `eoi`.
- `pending`  out  N_SRC  current pending bits.

## Operation
- Edge detect:
  - `src_q <= irq_src` every cycle.
  - `edge = irq_src & ~src_q`.
  - `src_q` resets to 0, so a line that is high at reset release counts as an edge.
- Pending update: `pending <= (pending & ~clr) | edge`.
  - `clr` is a one-hot of `irq_id`, asserted only in the acceptance cycle.
  - If set and clear hit the same bit in the same cycle, set wins.
- Mask register: `mask <= cfg_mask` when `cfg_we` is high. The new mask is used from the next cycle.
- Request vector: `req = pending & mask`.
  - Priority is fixed: lowest index wins.
  - Masked pending bits are retained and fire once unmasked.
- FSM states: IDLE, FIRE, SERVICE.
  - IDLE → FIRE when `req != 0`. `irq_id` latches the winning index and `interrupt <= 1`.
  - FIRE → SERVICE when `pc_write == 1`. This is the acceptance cycle: clear `pending[irq_id]`, `interrupt <= 0`, `in_service <= 1`.
  - FIRE → FIRE while `pc_write == 0`. `interrupt` holds at 1 and `irq_id` holds.
  - SERVICE → IDLE on `eoi == 1`: `in_service <= 0`.
  - SERVICE → SERVICE otherwise. New edges still set `pending`.
- `eoi` is ignored in IDLE and in FIRE.
- No nesting: at most one interrupt in flight.
- A mask change while in FIRE or SERVICE does not cancel the current interrupt.
- `irq_id` is stable from IDLE→FIRE until the next IDLE→FIRE transition.
- `in_service` is high in SERVICE only; it reads 0 in FIRE.
- Async reset clears all state and returns the FSM to IDLE, aborting any FIRE or SERVICE.

## Timing
- Reset values:
  - `interrupt` = 0
  - `irq_id` = 0
  - `in_service` = 0
  - `pending` = 0
  - `mask` = 0 (all sources disabled)
  - `src_q` = 0
  - FSM = IDLE
- Latency, with the source unmasked and the FSM in IDLE:
  - `irq_src[i]` first sampled high at edge k sets `pending[i]` after edge k.
  - `interrupt` is high after edge k+1.
  - The source only needs to be high at one sampling edge.
- `interrupt` is high for exactly one cycle if `pc_write` = 1 in that cycle; otherwise it stays high until the first cycle in which `pc_write` = 1.
- Back-to-back interrupts:
  - `eoi` sampled at edge m → IDLE after edge m.
  - The next `interrupt` rises after edge m+1 at the earliest, so there is at least one idle cycle between pulses.
- An edge on a source while its pending bit is already 1 is lost: there is no counting.

## Test plan
1. Single source: mask=0xFF; pulse `irq_src[5]` one cycle at edge k → `pending` = 0x20 after k, `interrupt` = 1 and `irq_id` = 5 after k+1, `interrupt` = 0 and `in_service` = 1 after k+2, `pending` = 0x00.
2. Priority: mask=0xFF; raise `irq_src[6]` and `irq_src[2]` in the same cycle → first fire has `irq_id` = 2 with `pending` = 0x40 left; `eoi` → second fire has `irq_id` = 6, exactly one idle cycle between the two `interrupt` pulses.
3. Stall: hold `pc_write` = 0 for 3 cycles while in FIRE → `interrupt` stays 1 for 4 cycles, `irq_id` is constant, and the pending bit clears only in the cycle where `pc_write` = 1.
4. Masking: mask=0x00; edge on `irq_src[3]` → `pending` = 0x08 and `interrupt` stays 0; write mask=0x08 → `interrupt` rises 1 cycle after the write takes effect, `irq_id` = 3.
5. Service blocking and set-wins: in SERVICE with `irq_id` = 1, new edges on sources 0 and 1 → no `interrupt` until `eoi`; `pending` = 0x03. Also: an edge on `irq_src[4]` exactly in the acceptance cycle of source 4 leaves `pending[4]` = 1.
6. Reset mid-operation: assert `rst` low asynchronously in FIRE and in SERVICE → all outputs go to 0 immediately; after release with `irq_src[0]` held high and mask written to 0x01 → one interrupt with `irq_id` = 0, not repeated while the line stays high.
